button_event_classifier: RTL and testbench
==========================================

BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 SHALL have parameter LONG_TIME, default 50_000_000, meaning cycles of continuous press that classify a press as LONG.
REQ-002 SHALL have parameter DOUBLE_GAP, default 12_500_000, meaning the maximum released cycles between two presses for them to count as DOUBLE.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port button_in, input, 1 bit: the already-debounced button level, synchronous to clk.
REQ-006 SHALL have port event_valid, output, 1 bit: event_code holds a pending event.
REQ-007 SHALL have port event_ready, input, 1 bit: the consumer accepts the event.
REQ-008 SHALL have port event_code, output, 2 bits: 01 = SHORT, 10 = LONG, 11 = DOUBLE, 00 = none.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag, set when an event was dropped.

Function
REQ-010 SHALL register button_in into btn_prev; press = button_in && !btn_prev; release = !button_in && btn_prev.
REQ-011 SHALL implement the states IDLE, PRESSED, LONG_HELD, WAIT_GAP and SECOND_PRESSED, using one counter of at least 26 bits.
REQ-012 IDLE: on press, SHALL go to PRESSED and clear the counter.
REQ-013 PRESSED: SHALL increment the counter each cycle; on release, SHALL go to WAIT_GAP and clear the counter; when counter == LONG_TIME-1 with the button still high, SHALL emit LONG and go to LONG_HELD.
REQ-014 LONG_HELD: on release, SHALL go to IDLE and emit no event.
REQ-015 WAIT_GAP: SHALL increment the counter each cycle; on press, SHALL go to SECOND_PRESSED; when counter == DOUBLE_GAP-1 with no press, SHALL emit SHORT and go to IDLE.
REQ-016 SECOND_PRESSED: on release, SHALL emit DOUBLE and go to IDLE, regardless of hold length.
REQ-017 If release and the timeout occur in the same cycle in PRESSED, release SHALL win; if press and the timeout occur in the same cycle in WAIT_GAP, press SHALL win.
REQ-018 An emitted event SHALL appear at the outputs (event_valid=1, event_code set) in the cycle after the triggering edge.
REQ-019 event_valid and event_code SHALL hold stable until event_valid && event_ready on a rising edge; after that edge, event_valid SHALL be 0 unless a new event is emitted in the same cycle.
REQ-020 On emit while event_valid && !event_ready, the new event SHALL be dropped, the old one kept, and overflow set to 1.
REQ-021 On emit in the same cycle as an accept, the new event SHALL load and event_valid SHALL remain 1.
REQ-022 overflow SHALL clear only on reset.

Reset
REQ-023 While reset_n=0, the block SHALL immediately force state=IDLE, counter=0, btn_prev=0, event_valid=0, event_code=00 and overflow=0.
REQ-024 A button held through reset deassertion SHALL register as a press one cycle after release of reset.
REQ-025 A reset asserted mid-sequence SHALL discard any partial classification.

Structure
REQ-026 Package button_pkg SHALL hold the event_code enum (NONE, SHORT, LONG, DOUBLE) and the state enum.
REQ-027 Sub-module edge_detect SHALL produce the press and release pulses from button_in.
REQ-028 The event output register SHALL be implemented inline.

Verification (LONG_TIME=8, DOUBLE_GAP=5)
REQ-029 Press held 3 cycles, then released 5 cycles -> event_code=01 valid exactly once.
REQ-030 Press held 10 cycles -> event_code=10 valid in cycle 9 after press; no event on release.
REQ-031 Press 2, release 2, press 2, release -> event_code=11 once; no SHORT emitted.
REQ-032 event_ready=0 with two SHORT sequences -> first code held, overflow=1; then event_ready=1 -> valid drops next cycle.
REQ-033 Reset pulse in WAIT_GAP -> all outputs 0, no event; subsequent short press classifies normally.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types for the button event classifier: event codes, FSM states and
// the width of the shared hold/gap counter.
package button_pkg;

    // Wide enough for the default LONG_TIME and DOUBLE_GAP at any sane clock.
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        SHORT  = 2'b01,
        LONG   = 2'b10,
        DOUBLE = 2'b11
    } event_code_t;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND_PRESSED
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Registers the debounced button level and derives single-cycle press and
// release pulses from the current level versus the previous one.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic button_in,
    output logic press,
    output logic release_edge
);

    logic btn_prev;

    // Remember last cycle's button level.
    // NOTE: non-blocking assignment keeps every register updating from the
    // values of the previous cycle, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= button_in;
        end
    end

    // A button held through reset shows up as a press on the first cycle
    // after reset, because btn_prev starts at 0.
    assign press        =  button_in && !btn_prev;
    assign release_edge = !button_in &&  btn_prev;

endmodule

// File: rtl/button_event_classifier.sv
// Classifies button activity into SHORT, LONG and DOUBLE events and presents
// them on a valid/ready output with a sticky overflow flag for dropped events.
module button_event_classifier
    import button_pkg::*;
#(
    parameter int LONG_TIME  = 50_000_000,
    parameter int DOUBLE_GAP = 12_500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_in,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [1:0] event_code,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

    logic             press;
    logic             release_edge;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             emit;
    event_code_t      emit_code;
    event_code_t      code_reg;

    edge_detect u_edge_detect (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_in    (button_in),
        .press        (press),
        .release_edge (release_edge)
    );

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state, counter and event-emission logic.
    // NOTE: every output of this block gets a default first, so no branch can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        emit       = 1'b0;
        emit_code  = NONE;
        case (state)
            IDLE: begin
                if (press) begin
                    state_next = PRESSED;
                    count_next = '0;
                end
            end
            PRESSED: begin
                // Release is checked first so it wins over the long timeout.
                if (release_edge) begin
                    state_next = WAIT_GAP;
                    count_next = '0;
                end else if (count == LONG_LAST) begin
                    state_next = LONG_HELD;
                    emit       = 1'b1;
                    emit_code  = LONG;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            LONG_HELD: begin
                if (release_edge) begin
                    state_next = IDLE;
                end
            end
            WAIT_GAP: begin
                // A second press wins over the gap timeout.
                if (press) begin
                    state_next = SECOND_PRESSED;
                end else if (count == GAP_LAST) begin
                    state_next = IDLE;
                    emit       = 1'b1;
                    emit_code  = SHORT;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            SECOND_PRESSED: begin
                if (release_edge) begin
                    state_next = IDLE;
                    emit       = 1'b1;
                    emit_code  = DOUBLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Event output register: load when empty or being accepted, otherwise
    // drop the new event and flag overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_valid <= 1'b0;
            code_reg    <= NONE;
            overflow    <= 1'b0;
        end else if (emit) begin
            if (!event_valid || event_ready) begin
                event_valid <= 1'b1;
                code_reg    <= emit_code;
            end else begin
                overflow    <= 1'b1;
            end
        end else if (event_valid && event_ready) begin
            event_valid <= 1'b0;
            code_reg    <= NONE;
        end
    end

    assign event_code = code_reg;

endmodule

// File: tb/tb_button_event_classifier.sv
// Self-checking bench for button_event_classifier: a run-length behavioural
// model checked every cycle, directed scenarios with literal expectations,
// then randomized button activity, consumer back-pressure and resets.
module tb_button_event_classifier;

    localparam int LT = 8;
    localparam int DG = 5;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       button_in   = 1'b0;
    logic       event_ready = 1'b1;
    logic       event_valid;
    logic [1:0] event_code;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state.
    int         runs[$];
    bit         active    = 1'b0;
    bit         long_done = 1'b0;
    logic       m_prev    = 1'b0;
    logic       m_valid   = 1'b0;
    logic [1:0] m_code    = 2'b00;
    logic       m_ovf     = 1'b0;

    int         nv;
    logic [1:0] lc;
    int         lat;
    bit         found;

    always #5 clk = ~clk;

    button_event_classifier #(
        .LONG_TIME  (LT),
        .DOUBLE_GAP (DG)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .button_in   (button_in),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_code  (event_code),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the current sequence is a list of alternating run lengths
    // starting with the press. LONG fires when the first high run reaches
    // LT+1 cycles (press cycle included), SHORT when the gap run reaches DG+1,
    // DOUBLE when a fourth run (second release) starts.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                runs.delete();
                active    = 1'b0;
                long_done = 1'b0;
                m_prev    = 1'b0;
                m_valid   = 1'b0;
                m_code    = 2'b00;
                m_ovf     = 1'b0;
            end else begin
                automatic logic       b    = button_in;
                automatic bit         emit = 1'b0;
                automatic logic [1:0] code = 2'b00;
                if (!active) begin
                    if (b && !m_prev) begin
                        active    = 1'b1;
                        long_done = 1'b0;
                        runs.delete();
                        runs.push_back(1);
                    end
                end else begin
                    automatic bit hi = (runs.size() % 2) == 1;
                    automatic int n;
                    if (b == hi) runs[runs.size()-1]++;
                    else         runs.push_back(1);
                    n = runs.size();
                    if (long_done) begin
                        if (n == 2) active = 1'b0;
                    end else if (n == 1 && runs[0] == LT + 1) begin
                        emit = 1'b1; code = 2'b10; long_done = 1'b1;
                    end else if (n == 2 && runs[1] == DG + 1) begin
                        emit = 1'b1; code = 2'b01; active = 1'b0;
                    end else if (n == 4) begin
                        emit = 1'b1; code = 2'b11; active = 1'b0;
                    end
                end
                if (emit) begin
                    if (!m_valid || event_ready) begin
                        m_valid = 1'b1;
                        m_code  = code;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (m_valid && event_ready) begin
                    m_valid = 1'b0;
                    m_code  = 2'b00;
                end
                m_prev = b;
            end
        end
    end

    // Compare DUT outputs against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_valid",    event_valid, m_valid);
                check("model_code",     event_code,  m_code);
                check("model_overflow", overflow,    m_ovf);
            end
        end
    end

    // Hold the button at level b for n cycles, counting cycles with an event
    // pending and remembering the last code seen.
    task automatic hold(input logic b, input int n);
        button_in = b;
        repeat (n) begin
            @(negedge clk);
            if (event_valid) begin
                nv++;
                lc = event_code;
            end
            #1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid",    event_valid, 1'b0);
        check("reset_code",     event_code,  2'b00);
        check("reset_overflow", overflow,    1'b0);
        cmp_en = 1'b1;
        #1;
        reset_n = 1'b1;
        nv = 0; lc = 2'b00;
        hold(1'b0, 3);

        // Long press: valid on the 9th cycle after the press, silent release.
        button_in = 1'b1;
        lat = 0; found = 1'b0; lc = 2'b00;
        for (int i = 1; i <= 30 && !found; i++) begin
            @(negedge clk);
            if (event_valid) begin
                found = 1'b1;
                lat   = i;
                lc    = event_code;
            end
            #1;
        end
        check("long_latency", lat, 9);
        check("long_code",    lc,  2'b10);
        nv = 0;
        hold(1'b1, 1);
        hold(1'b0, 12);
        check("long_release_silent", nv, 0);

        // Short press.
        nv = 0; lc = 2'b00;
        hold(1'b1, 3);
        hold(1'b0, 12);
        check("short_count", nv, 1);
        check("short_code",  lc, 2'b01);

        // Release on the same cycle as the long timeout: release wins.
        nv = 0; lc = 2'b00;
        hold(1'b1, LT);
        hold(1'b0, 12);
        check("long_edge_release_count", nv, 1);
        check("long_edge_release_code",  lc, 2'b01);

        // One cycle longer: LONG.
        nv = 0; lc = 2'b00;
        hold(1'b1, LT + 1);
        hold(1'b0, 12);
        check("long_edge_hold_count", nv, 1);
        check("long_edge_hold_code",  lc, 2'b10);

        // Double press.
        nv = 0; lc = 2'b00;
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 12);
        check("double_count", nv, 1);
        check("double_code",  lc, 2'b11);

        // Second press on the same cycle as the gap timeout: press wins.
        nv = 0; lc = 2'b00;
        hold(1'b1, 2);
        hold(1'b0, DG);
        hold(1'b1, 2);
        hold(1'b0, 12);
        check("gap_edge_press_count", nv, 1);
        check("gap_edge_press_code",  lc, 2'b11);

        // Second press one cycle too late: two separate SHORTs.
        nv = 0; lc = 2'b00;
        hold(1'b1, 2);
        hold(1'b0, DG + 1);
        hold(1'b1, 2);
        hold(1'b0, 12);
        check("gap_late_count", nv, 2);
        check("gap_late_code",  lc, 2'b01);

        // Back-pressure: second SHORT is dropped, first held, overflow set.
        event_ready = 1'b0;
        hold(1'b1, 3);
        hold(1'b0, 10);
        hold(1'b1, 3);
        hold(1'b0, 10);
        check("bp_valid",    event_valid, 1'b1);
        check("bp_code",     event_code,  2'b01);
        check("bp_overflow", overflow,    1'b1);
        event_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_valid",    event_valid, 1'b0);
        check("bp_sticky_overflow", overflow,   1'b1);
        #1;

        // Reset in WAIT_GAP discards the sequence and clears overflow.
        hold(1'b1, 3);
        hold(1'b0, 2);
        reset_n = 1'b0;
        #1;
        check("midreset_valid",    event_valid, 1'b0);
        check("midreset_code",     event_code,  2'b00);
        check("midreset_overflow", overflow,    1'b0);
        hold(1'b0, 2);
        reset_n = 1'b1;
        nv = 0;
        hold(1'b0, 10);
        check("midreset_no_event", nv, 0);
        nv = 0; lc = 2'b00;
        hold(1'b1, 3);
        hold(1'b0, 12);
        check("post_reset_short_count", nv, 1);
        check("post_reset_short_code",  lc, 2'b01);

        // Randomized runs with back-pressure and occasional reset pulses.
        for (int s = 0; s < 400; s++) begin
            automatic int len = $urandom_range(1, 12);
            button_in = ~button_in;
            repeat (len) begin
                event_ready = ($urandom_range(0, 3) != 0);
                reset_n     = ($urandom_range(0, 99) != 0);
                @(negedge clk);
                #1;
            end
        end
        reset_n = 1'b1;
        button_in = 1'b0;
        event_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
